// File: rtl/round_arbiter_if.sv
// round_arbiter_if: requester/result bundle for round_arbiter.
//   slave  modport - the arbiter: samples req_valid/req_mag/out_ready,
//                    drives req_ready/out_valid/out_data/out_chan/xfer_cnt.
//   master modport - the environment side (producers + downstream stage).
// req_mag is flattened: requester i lives at [17*i+16 : 17*i].
interface round_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int CW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [17*NREQ-1:0] req_mag;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic [12:0]        out_data;
  logic [CW-1:0]      out_chan;
  logic               out_ready;
  logic [15:0]        xfer_cnt;

  modport slave (
    input  req_valid, req_mag, out_ready,
    output req_ready, out_valid, out_data, out_chan, xfer_cnt
  );

  modport master (
    output req_valid, req_mag, out_ready,
    input  req_ready, out_valid, out_data, out_chan, xfer_cnt
  );
endinterface

// File: rtl/round_arbiter.sv
// round_arbiter: round-robin share of one 17->13 bit rounding stage among
// NREQ requesters. One grant per cycle, result registered with its source
// channel index, single-entry output buffer with valid/ready drain.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high
//   bus    - round_arbiter_if.slave (req_valid/req_mag/req_ready in,
//            out_valid/out_data/out_chan/out_ready out, xfer_cnt)
//
// Build option:
//   ROUND_SAT_EN - when defined, the single overflowing input
//                  (mag[16:4]=1FFF, mag[3]=1) saturates to 13'h1FFF instead
//                  of wrapping to 0.

// Per-lane rounder: drop 4 LSBs, round half up. Every lane rounds its own
// magnitude in parallel; the grant just picks one lane's result, so the
// mag->register path is a mux after a short adder.
module round_lane (
  input  logic [16:0] mag,
  output logic [12:0] rnd
);
`ifdef ROUND_SAT_EN
  logic [13:0] sum;
  assign sum = {1'b0, mag[16:4]} + {13'b0, mag[3]};
  assign rnd = sum[13] ? 13'h1FFF : sum[12:0];
`else
  // Plain 13-bit add: 1FFF + 1 wraps to 0.
  assign rnd = mag[16:4] + {12'b0, mag[3]};
`endif
endmodule

module round_arbiter #(
  parameter int NREQ = 4
) (
  input  logic           clk,
  input  logic           reset,
  round_arbiter_if.slave bus
);
  localparam int CW = $clog2(NREQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  typedef struct packed {
    logic [12:0]   data;
    logic [CW-1:0] chan;
  } resp_t;

  // (p + k) mod NREQ without relying on NREQ being a power of two.
  function automatic logic [CW-1:0] rot(input logic [CW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return CW'(s);
  endfunction

  state_t                   state;
  resp_t                    resp_q;
  logic [CW-1:0]            ptr;
  logic [15:0]              cnt;

  logic [NREQ-1:0][16:0]    mag_arr;
  logic [NREQ-1:0][12:0]    rnd_arr;
  logic                     hit;
  logic [CW-1:0]            gidx;
  logic                     can_load;
  logic [NREQ-1:0]          gnt;
  logic                     xfer;
  logic                     drain;

  assign mag_arr = bus.req_mag;

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    round_lane u_lane (
      .mag (mag_arr[i]),
      .rnd (rnd_arr[i])
    );
  end

  // Rotating priority search starting at ptr. Walking from the far end
  // back to ptr lets the last hit (closest to ptr) win without a found flag.
  always_comb begin
    hit  = 1'b0;
    gidx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rot(ptr, k)]) begin
        hit  = 1'b1;
        gidx = rot(ptr, k);
      end
    end
  end

  // out_ready only matters while holding a result.
  assign can_load = (state == EMPTY) || bus.out_ready;
  assign gnt      = hit ? (NREQ'(1) << gidx) : '0;
  assign xfer     = !reset && can_load && hit;
  assign drain    = (state == FULL) && bus.out_ready;

  assign bus.req_ready = xfer ? gnt : '0;

  // Single-entry output buffer. The state register is the valid bit; a
  // drain and a load on the same edge just overwrite the entry (no bubble).
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      resp_q <= '0;
      ptr    <= '0;
      cnt    <= '0;
    end else begin
      if (drain) cnt <= cnt + 16'd1;

      if (xfer) begin
        resp_q.data <= rnd_arr[gidx];
        resp_q.chan <= gidx;
        ptr         <= rot(gidx, 1);
      end

      case (state)
        EMPTY: if (xfer) state <= FULL;
        FULL:  if (bus.out_ready && !xfer) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = resp_q.data;
  assign bus.out_chan  = resp_q.chan;
  assign bus.xfer_cnt  = cnt;
endmodule
